lock_controller: RTL and testbench
==================================

# lock_controller

Sequencing controller for the keypad lock. Consumes the keypad decoder's `userPin`/`validPin` stream, compares entries against the stored PIN, and drives the lock state. It enforces lockout after repeated failures, auto-relocks, and runs a two-entry PIN-change sequence. Its `status` output feeds back into the keypad decoder's `status` input, which gates the keypad.

## Interface
- `DEFAULT_PIN`, 16'h1234 — stored PIN after reset; four BCD nibbles, first digit in [15:12].
- `MAX_FAILS`, 3 — consecutive wrong entries that trigger lockout; range 1–7.
- `LOCKOUT_CYCLES`, 15000 — lockout duration in clock cycles (30 s at 500 Hz).
- `AUTO_LOCK_CYCLES`, 5000 — idle cycles in UNLOCKED before relock; 0 disables auto-relock.
- `ADJ_TIMEOUT`, 5000 — idle cycles allowed in NEW_PIN/CONFIRM before abort.

- `clk_500Hz` input 1 — single clock; all logic on its rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `userPin` input 16 — entered PIN; valid only in the cycle `validPin`=1.
- `validPin` input 1 — one-cycle strobe from the keypad decoder.
- `lock_btn` input 1 — debounced one-cycle pulse: lock, or abort adjustment.
- `adjust_btn` input 1 — debounced one-cycle pulse: enter PIN change (UNLOCKED only).
- `status` output 1 — 1 only in UNLOCKED; the keypad decoder is disabled while it is 1.
- `state_code` output 3 — current state encoding, for display.
- `fail_count` output 3 — consecutive failures so far.
- `alarm` output 1 — 1 throughout LOCKOUT.
- `pin_changed` output 1 — one-cycle pulse when a new PIN is committed.
- `pin_error` output 1 — one-cycle pulse on any rejected entry (wrong PIN, or confirm mismatch).

## Operation
- States and codes: LOCKED=0, UNLOCKED=1, LOCKOUT=2, NEW_PIN=3, CONFIRM=4. Codes 5–7 are illegal and recover to LOCKED on the next cycle.
- LOCKED, on `validPin`:
  - Match with stored PIN: go to UNLOCKED, clear `fail_count`.
  - Mismatch with `fail_count`+1 < `MAX_FAILS`: increment `fail_count`, pulse `pin_error`.
  - Mismatch with `fail_count`+1 == `MAX_FAILS`: go to LOCKOUT, load timer with `LOCKOUT_CYCLES`−1, clear `fail_count`, pulse `pin_error`.
- LOCKOUT: `validPin` and both buttons are ignored. The timer decrements each cycle; when it reaches 0, go to LOCKED.
- UNLOCKED:
  - `lock_btn`: go to LOCKED.
  - `adjust_btn`: go to NEW_PIN.
  - If `lock_btn` and `adjust_btn` are both high, lock wins.
  - Auto-lock timer is loaded with `AUTO_LOCK_CYCLES`−1 on entry and decrements each cycle; at 0, go to LOCKED. Never expires when the parameter is 0.
  - `validPin` is ignored.
- NEW_PIN:
  - `validPin`: capture `userPin` into `pending_pin`, go to CONFIRM.
  - `lock_btn` or timeout: go to UNLOCKED.
- CONFIRM, on `validPin`:
  - `userPin`==`pending_pin`: write it to the stored PIN, pulse `pin_changed`, go to UNLOCKED.
  - Otherwise: pulse `pin_error`, go to NEW_PIN; the stored PIN is unchanged.
  - `lock_btn` or timeout: go to UNLOCKED; the stored PIN is unchanged.
- In NEW_PIN/CONFIRM the timer is reloaded with `ADJ_TIMEOUT`−1 on every state entry and on every `validPin`.
- Stored PIN is a 16-bit register. Comparison is an exact 16-bit equality; no digit arithmetic.

## Timing
- All outputs are registered. A `validPin` sampled at edge n is reflected in `state_code`/`status`/pulses after edge n; latency is 1 cycle.
- `pin_changed` and `pin_error` are high for exactly 1 cycle.
- Reset values:
  - state = LOCKED, `status`=0, `state_code`=0, `fail_count`=0.
  - `alarm`=0, `pin_changed`=0, `pin_error`=0.
  - stored PIN = `DEFAULT_PIN`, `pending_pin`=0, timer=0.
- Reset mid-sequence (LOCKOUT, NEW_PIN, CONFIRM) returns to LOCKED and restores `DEFAULT_PIN`; an uncommitted `pending_pin` is discarded.
- Simultaneous events:
  - `validPin` with timer expiry: the expiry wins, and the entry is dropped.
  - `validPin` with `lock_btn` in NEW_PIN/CONFIRM: abort wins.
- Timer width is $clog2 of the largest timing parameter, minimum 1 bit. One counter is shared, because only one timeout is active per state.

## Structure
- Package `lock_pkg`:
  - state enum and its 3-bit codes;
  - PIN width constant (16);
  - blank-digit constant (4'hF), shared with the display path.
- One sub-module, `lock_timer`: load value, load strobe, run enable, and an `expired` flag that is high when the count is 0 and `run` is asserted.
- The FSM, compare logic and PIN registers live in `lock_controller`.

## Test plan
- Reset, then `userPin`=16'h1234 with `validPin` → `status`=1 and `state_code`=1 one cycle later; `fail_count`=0.
- Three entries of 16'h0000 from LOCKED → `pin_error` pulses ×3, `fail_count` reads 1 then 2; LOCKOUT on the third entry with `alarm`=1. A correct PIN entered during lockout is ignored. Return to LOCKED after exactly 15000 cycles.
- UNLOCKED, `adjust_btn`, enter 16'h5678, then 16'h5678 → `pin_changed` pulse. After `lock_btn`, entering 16'h1234 is rejected and entering 16'h5678 unlocks.
- PIN-change mismatch: enter 16'h5678, then 16'h5679 → `pin_error` pulse, state NEW_PIN, stored PIN still 16'h1234.
- UNLOCKED with no activity → LOCKED after 5000 cycles. `lock_btn` and `adjust_btn` in the same cycle → LOCKED.
- Reset asserted in CONFIRM after a custom PIN was committed → LOCKED, and 16'h1234 unlocks.

Source files
------------

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and constants for the keypad lock sequencer
package lock_pkg;

  localparam int PIN_W = 16;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_UNLOCKED = 3'd1,
    ST_LOCKOUT  = 3'd2,
    ST_NEW_PIN  = 3'd3,
    ST_CONFIRM  = 3'd4
  } lock_state_t;

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter shared by lockout, auto-lock and adjust timeouts
module lock_timer #(
  parameter int W = 14
) (
  input  logic         clk_500Hz,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk_500Hz) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = run && (count == '0);

endmodule

// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - PIN compare, lockout, auto-relock and PIN-change sequencing
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [PIN_W-1:0] DEFAULT_PIN      = 16'h1234,
  parameter int               MAX_FAILS        = 3,
  parameter int               LOCKOUT_CYCLES   = 15000,
  parameter int               AUTO_LOCK_CYCLES = 5000,
  parameter int               ADJ_TIMEOUT      = 5000
) (
  input  logic             clk_500Hz,
  input  logic             rst,
  input  logic [PIN_W-1:0] userPin,
  input  logic             validPin,
  input  logic             lock_btn,
  input  logic             adjust_btn,
  output logic             status,
  output logic [2:0]       state_code,
  output logic [2:0]       fail_count,
  output logic             alarm,
  output logic             pin_changed,
  output logic             pin_error
);

  localparam int MAX_AB = (LOCKOUT_CYCLES > AUTO_LOCK_CYCLES) ? LOCKOUT_CYCLES : AUTO_LOCK_CYCLES;
  localparam int MAX_T  = (MAX_AB > ADJ_TIMEOUT) ? MAX_AB : ADJ_TIMEOUT;
  localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TW-1:0] LOCKOUT_VAL = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] AUTO_VAL    = (AUTO_LOCK_CYCLES == 0) ? '0 : TW'(AUTO_LOCK_CYCLES - 1);
  localparam logic [TW-1:0] ADJ_VAL     = TW'(ADJ_TIMEOUT - 1);
  localparam logic          AUTO_EN     = (AUTO_LOCK_CYCLES != 0);

  lock_state_t      state, state_n;
  logic [2:0]       fail_n;
  logic [PIN_W-1:0] stored_pin, stored_n;
  logic [PIN_W-1:0] pending_pin, pending_n;
  logic             changed_n, error_n;
  logic             tmr_load, tmr_run, expired;
  logic [TW-1:0]    tmr_val;

  lock_timer #(.W(TW)) u_timer (
    .clk_500Hz (clk_500Hz),
    .rst       (rst),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .run       (tmr_run),
    .expired   (expired)
  );

  always_ff @(posedge clk_500Hz) begin
    if (rst) begin
      state       <= ST_LOCKED;
      stored_pin  <= DEFAULT_PIN;
      pending_pin <= '0;
      fail_count  <= '0;
      status      <= 1'b0;
      state_code  <= 3'd0;
      alarm       <= 1'b0;
      pin_changed <= 1'b0;
      pin_error   <= 1'b0;
    end else begin
      state       <= state_n;
      stored_pin  <= stored_n;
      pending_pin <= pending_n;
      fail_count  <= fail_n;
      status      <= (state_n == ST_UNLOCKED);
      state_code  <= state_n;
      alarm       <= (state_n == ST_LOCKOUT);
      pin_changed <= changed_n;
      pin_error   <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    fail_n    = fail_count;
    stored_n  = stored_pin;
    pending_n = pending_pin;
    changed_n = 1'b0;
    error_n   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_run   = 1'b0;
    case (state)
      ST_LOCKED: begin
        if (validPin) begin
          if (userPin == stored_pin) begin
            state_n  = ST_UNLOCKED;
            fail_n   = '0;
            tmr_load = 1'b1;
            tmr_val  = AUTO_VAL;
          end else if (({1'b0, fail_count} + 4'd1) >= 4'(MAX_FAILS)) begin
            state_n  = ST_LOCKOUT;
            fail_n   = '0;
            error_n  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = LOCKOUT_VAL;
          end else begin
            fail_n  = fail_count + 3'd1;
            error_n = 1'b1;
          end
        end
      end
      ST_LOCKOUT: begin
        tmr_run = 1'b1;
        if (expired) state_n = ST_LOCKED;
      end
      ST_UNLOCKED: begin
        tmr_run = AUTO_EN;
        if (lock_btn || expired) begin
          state_n = ST_LOCKED;
        end else if (adjust_btn) begin
          state_n  = ST_NEW_PIN;
          tmr_load = 1'b1;
          tmr_val  = ADJ_VAL;
        end
      end
      ST_NEW_PIN, ST_CONFIRM: begin
        tmr_run = 1'b1;
        // Abort and timeout both dominate a same-cycle entry.
        if (lock_btn || expired) begin
          state_n  = ST_UNLOCKED;
          tmr_load = 1'b1;
          tmr_val  = AUTO_VAL;
        end else if (validPin) begin
          tmr_load = 1'b1;
          tmr_val  = ADJ_VAL;
          if (state == ST_NEW_PIN) begin
            pending_n = userPin;
            state_n   = ST_CONFIRM;
          end else if (userPin == pending_pin) begin
            stored_n  = pending_pin;
            changed_n = 1'b1;
            state_n   = ST_UNLOCKED;
            tmr_val   = AUTO_VAL;
          end else begin
            error_n = 1'b1;
            state_n = ST_NEW_PIN;
          end
        end
      end
      default: state_n = ST_LOCKED;
    endcase
  end

endmodule

// File: tb/tb_lock_controller.sv
// tb/tb_lock_controller.sv - directed self-checking bench for lock_controller
module tb_lock_controller;

  logic        clk_500Hz = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] userPin = '0;
  logic        validPin = 1'b0;
  logic        lock_btn = 1'b0;
  logic        adjust_btn = 1'b0;
  logic        status;
  logic [2:0]  state_code;
  logic [2:0]  fail_count;
  logic        alarm;
  logic        pin_changed;
  logic        pin_error;

  int vectors = 0;
  int miscompares = 0;

  lock_controller dut (
    .clk_500Hz   (clk_500Hz),
    .rst         (rst),
    .userPin     (userPin),
    .validPin    (validPin),
    .lock_btn    (lock_btn),
    .adjust_btn  (adjust_btn),
    .status      (status),
    .state_code  (state_code),
    .fail_count  (fail_count),
    .alarm       (alarm),
    .pin_changed (pin_changed),
    .pin_error   (pin_error)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_500Hz);
    #1;
  endtask

  task automatic enter(input logic [15:0] pin);
    userPin  = pin;
    validPin = 1'b1;
    step();
    validPin = 1'b0;
  endtask

  task automatic press_lock();
    lock_btn = 1'b1;
    step();
    lock_btn = 1'b0;
  endtask

  task automatic press_adj();
    adjust_btn = 1'b1;
    step();
    adjust_btn = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_state", 16'(state_code), 16'd0);
    chk("rst_status", 16'(status), 16'd0);
    chk("rst_fail", 16'(fail_count), 16'd0);
    chk("rst_alarm", 16'(alarm), 16'd0);
    chk("rst_changed", 16'(pin_changed), 16'd0);
    chk("rst_error", 16'(pin_error), 16'd0);

    enter(16'h1234);
    chk("unlock_state", 16'(state_code), 16'd1);
    chk("unlock_status", 16'(status), 16'd1);
    chk("unlock_fail", 16'(fail_count), 16'd0);
    press_lock();
    chk("lock_state", 16'(state_code), 16'd0);
    chk("lock_status", 16'(status), 16'd0);

    enter(16'h0000);
    chk("bad1_err", 16'(pin_error), 16'd1);
    chk("bad1_fail", 16'(fail_count), 16'd1);
    chk("bad1_state", 16'(state_code), 16'd0);
    step();
    chk("bad1_err_drop", 16'(pin_error), 16'd0);
    enter(16'h0000);
    chk("bad2_err", 16'(pin_error), 16'd1);
    chk("bad2_fail", 16'(fail_count), 16'd2);
    enter(16'h0000);
    chk("bad3_err", 16'(pin_error), 16'd1);
    chk("lockout_state", 16'(state_code), 16'd2);
    chk("lockout_alarm", 16'(alarm), 16'd1);
    chk("lockout_fail", 16'(fail_count), 16'd0);
    enter(16'h1234);
    chk("lockout_ignore", 16'(state_code), 16'd2);
    chk("lockout_ignore_status", 16'(status), 16'd0);
    for (int n = 2; n < 15000; n++) step();
    chk("lockout_last", 16'(state_code), 16'd2);
    chk("lockout_last_alarm", 16'(alarm), 16'd1);
    step();
    chk("lockout_end", 16'(state_code), 16'd0);
    chk("lockout_end_alarm", 16'(alarm), 16'd0);

    enter(16'h1234);
    chk("chg_unlock", 16'(state_code), 16'd1);
    press_adj();
    chk("chg_newpin", 16'(state_code), 16'd3);
    chk("chg_status", 16'(status), 16'd0);
    enter(16'h5678);
    chk("chg_confirm", 16'(state_code), 16'd4);
    enter(16'h5678);
    chk("chg_pulse", 16'(pin_changed), 16'd1);
    chk("chg_back", 16'(state_code), 16'd1);
    step();
    chk("chg_pulse_drop", 16'(pin_changed), 16'd0);
    press_lock();
    enter(16'h1234);
    chk("old_pin_err", 16'(pin_error), 16'd1);
    chk("old_pin_state", 16'(state_code), 16'd0);
    enter(16'h5678);
    chk("new_pin_state", 16'(state_code), 16'd1);
    chk("new_pin_fail", 16'(fail_count), 16'd0);

    do_reset();
    enter(16'h1234);
    press_adj();
    enter(16'h5678);
    enter(16'h5679);
    chk("mm_err", 16'(pin_error), 16'd1);
    chk("mm_state", 16'(state_code), 16'd3);
    chk("mm_changed", 16'(pin_changed), 16'd0);
    press_lock();
    chk("mm_abort", 16'(state_code), 16'd1);
    press_lock();
    enter(16'h1234);
    chk("mm_old_kept", 16'(state_code), 16'd1);

    for (int n = 1; n < 5000; n++) step();
    chk("auto_last", 16'(state_code), 16'd1);
    step();
    chk("auto_lock", 16'(state_code), 16'd0);

    enter(16'h1234);
    lock_btn   = 1'b1;
    adjust_btn = 1'b1;
    step();
    lock_btn   = 1'b0;
    adjust_btn = 1'b0;
    chk("both_btn", 16'(state_code), 16'd0);

    enter(16'h1234);
    press_adj();
    userPin  = 16'h4321;
    validPin = 1'b1;
    lock_btn = 1'b1;
    step();
    validPin = 1'b0;
    lock_btn = 1'b0;
    chk("abort_wins", 16'(state_code), 16'd1);

    press_adj();
    enter(16'h5678);
    enter(16'h5678);
    press_adj();
    enter(16'h1111);
    chk("pre_rst_confirm", 16'(state_code), 16'd4);
    do_reset();
    chk("mid_rst_state", 16'(state_code), 16'd0);
    enter(16'h5678);
    chk("mid_rst_custom_err", 16'(pin_error), 16'd1);
    enter(16'h1234);
    chk("mid_rst_default", 16'(state_code), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
